dbf_line_sequencer: RTL and testbench

//  Per-scan-line controller for the DBF channel array. On a line request it

---
 rtl/dbf_line_sequencer_if.sv | 30 +++
 rtl/dbf_line_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_dbf_line_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbf_line_sequencer_if.sv
// Channel-side bus of the DBF line sequencer.
// Carries the streamed config handshake (cfg_valid/cfg_data/cfg_ready) and
// the shared nets fanned out to every dbf_chNN instance (lut_wdata,
// dbf_lut_addr, dbf_lut_we, tx_en, start).
//   master : sequencer side (accepts config, drives channel nets)
//   slave  : config source / channel side
`timescale 1ns/1ps
interface dbf_line_sequencer_if #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 16
);
  logic               cfg_valid;
  logic [DATA_WD-1:0] cfg_data;
  logic               cfg_ready;
  logic [DATA_WD-1:0] lut_wdata;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic               tx_en;
  logic               start;

  modport master (
    input  cfg_valid, cfg_data,
    output cfg_ready, lut_wdata, dbf_lut_addr, dbf_lut_we, tx_en, start
  );

  modport slave (
    output cfg_valid, cfg_data,
    input  cfg_ready, lut_wdata, dbf_lut_addr, dbf_lut_we, tx_en, start
  );
endinterface

// File: rtl/dbf_line_sequencer.sv
// Per-scan-line controller for the DBF channel array.
// On line_req it optionally loads NUM_ZONES LUT words from the config stream,
// opens the TX window for TX_LEN cycles, idles DEAD_LEN cycles, then opens the
// receive window for RX_LEN cycles while stepping the LUT zone address with
// depth. Every output is registered.
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, ACTIVE-HIGH (1 = reset)
//   line_req     pulse, starts a line (only honoured in IDLE)
//   cfg_load     sampled with line_req, 1 = load the LUTs first
//   abort        level, terminates the current line
//   bus          channel/config bus (master modport)
//   line_busy    high whenever not IDLE
//   line_done    1-cycle pulse at normal completion
//   line_aborted 1-cycle pulse when abort ended a line
//   line_cnt     completed-line counter, wraps at 16 bits
`timescale 1ns/1ps
module dbf_line_sequencer #(
  parameter int ADDR_WD   = 8,
  parameter int DATA_WD   = 16,
  parameter int NUM_ZONES = 256,
  parameter int ZONE_SH   = 4,
  parameter int TX_LEN    = 16,
  parameter int DEAD_LEN  = 64,
  parameter int RX_LEN    = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_req,
  input  logic                 cfg_load,
  input  logic                 abort,
  dbf_line_sequencer_if.master bus,
  output logic                 line_busy,
  output logic                 line_done,
  output logic                 line_aborted,
  output logic [15:0]          line_cnt
);

  // One shared counter serves every phase, so size it for the longest one.
  localparam int MAX_A   = (NUM_ZONES > TX_LEN) ? NUM_ZONES : TX_LEN;
  localparam int MAX_B   = (DEAD_LEN > RX_LEN) ? DEAD_LEN : RX_LEN;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_WD  = $clog2(MAX_LEN + 1);

  localparam logic [CNT_WD-1:0] TX_LAST   = CNT_WD'(TX_LEN - 1);
  localparam logic [CNT_WD-1:0] DEAD_LAST = CNT_WD'(DEAD_LEN - 1);
  localparam logic [CNT_WD-1:0] RX_LAST   = CNT_WD'(RX_LEN - 1);
  localparam logic [CNT_WD-1:0] WORDS     = CNT_WD'(NUM_ZONES);
  localparam logic [CNT_WD-1:0] ZONE_LAST = CNT_WD'(NUM_ZONES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TX,
    S_DEAD,
    S_RX,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_WD-1:0]  cnt, cnt_n;
  logic               cfg_ready_q, cfg_ready_n;
  logic [DATA_WD-1:0] wdata_q, wdata_n;
  logic [ADDR_WD-1:0] addr_q, addr_n;
  logic               we_q, we_n;
  logic               tx_q, tx_n;
  logic               start_q, start_n;
  logic               busy_n, done_n, aborted_n;
  logic [15:0]        line_cnt_n;

  logic               accept;
  logic [CNT_WD-1:0]  s_next;
  logic [CNT_WD-1:0]  zone;
  logic [ADDR_WD-1:0] zone_addr;

  assign accept = bus.cfg_valid & cfg_ready_q;

  // Address for the sample that follows the current one, saturated at the
  // last zone so an RX window longer than NUM_ZONES zones holds the final entry.
  assign s_next    = cnt + CNT_WD'(1);
  assign zone      = s_next >> ZONE_SH;
  assign zone_addr = (zone > ZONE_LAST) ? ADDR_WD'(ZONE_LAST) : ADDR_WD'(zone);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wdata_n    = wdata_q;
    addr_n     = addr_q;
    we_n       = 1'b0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    line_cnt_n = line_cnt;

    case (state)
      S_IDLE: begin
        if (line_req) begin
          state_n = cfg_load ? S_LOAD : S_TX;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        // cnt == WORDS is a one-cycle tail that lets the final LUT write
        // strobe stand alone before tx_en rises.
        if (cnt == WORDS) begin
          state_n = S_TX;
          cnt_n   = '0;
          addr_n  = '0;
        end else if (accept) begin
          wdata_n = bus.cfg_data;
          addr_n  = ADDR_WD'(cnt);
          we_n    = 1'b1;
          cnt_n   = cnt + CNT_WD'(1);
        end
      end
      S_TX: begin
        if (cnt == TX_LAST) begin
          state_n = S_DEAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_WD'(1);
        end
      end
      S_DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_n = S_RX;
          cnt_n   = '0;
          addr_n  = '0;
        end else begin
          cnt_n = cnt + CNT_WD'(1);
        end
      end
      S_RX: begin
        if (cnt == RX_LAST) begin
          state_n    = S_DONE;
          cnt_n      = '0;
          addr_n     = '0;
          done_n     = 1'b1;
          line_cnt_n = line_cnt + 16'd1;
        end else begin
          cnt_n  = s_next;
          addr_n = zone_addr;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      addr_n     = '0;
      we_n       = 1'b0;
      done_n     = 1'b0;
      aborted_n  = 1'b1;
      line_cnt_n = line_cnt;
    end

    // Windows and handshake are registered images of the state being entered.
    tx_n        = (state_n == S_TX);
    start_n     = (state_n == S_RX);
    busy_n      = (state_n != S_IDLE);
    cfg_ready_n = (state_n == S_LOAD) && (cnt_n != WORDS);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cfg_ready_q  <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      tx_q         <= 1'b0;
      start_q      <= 1'b0;
      line_busy    <= 1'b0;
      line_done    <= 1'b0;
      line_aborted <= 1'b0;
      line_cnt     <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cfg_ready_q  <= cfg_ready_n;
      wdata_q      <= wdata_n;
      addr_q       <= addr_n;
      we_q         <= we_n;
      tx_q         <= tx_n;
      start_q      <= start_n;
      line_busy    <= busy_n;
      line_done    <= done_n;
      line_aborted <= aborted_n;
      line_cnt     <= line_cnt_n;
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.lut_wdata    = wdata_q;
  assign bus.dbf_lut_addr = addr_q;
  assign bus.dbf_lut_we   = we_q;
  assign bus.tx_en        = tx_q;
  assign bus.start        = start_q;

endmodule

// File: tb/tb_dbf_line_sequencer.sv
`timescale 1ns/1ps
module tb_dbf_line_sequencer;
  localparam int NZ    = 256;
  localparam int ZSH   = 4;
  localparam int TXL   = 16;
  localparam int DL    = 64;
  localparam int RXL   = 4096;
  localparam int TOT   = TXL + DL + RXL;
  localparam int RXL_B = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, line_req, cfg_load, abort;
  logic        line_busy, line_done, line_aborted;
  logic [15:0] line_cnt;
  logic        line_req_b;
  logic        line_busy_b, line_done_b, line_aborted_b;
  logic [15:0] line_cnt_b;

  dbf_line_sequencer_if #(.ADDR_WD(8), .DATA_WD(16)) bus ();
  dbf_line_sequencer_if #(.ADDR_WD(8), .DATA_WD(16)) bus_b ();

  dbf_line_sequencer #(
    .ADDR_WD(8), .DATA_WD(16), .NUM_ZONES(NZ), .ZONE_SH(ZSH),
    .TX_LEN(TXL), .DEAD_LEN(DL), .RX_LEN(RXL)
  ) dut (
    .clk(clk), .rst_n(rst), .line_req(line_req), .cfg_load(cfg_load), .abort(abort),
    .bus(bus), .line_busy(line_busy), .line_done(line_done),
    .line_aborted(line_aborted), .line_cnt(line_cnt)
  );

  // Long-RX instance: address must saturate at the last zone.
  dbf_line_sequencer #(
    .ADDR_WD(8), .DATA_WD(16), .NUM_ZONES(NZ), .ZONE_SH(ZSH),
    .TX_LEN(TXL), .DEAD_LEN(DL), .RX_LEN(RXL_B)
  ) dut_b (
    .clk(clk), .rst_n(rst), .line_req(line_req_b), .cfg_load(1'b0), .abort(1'b0),
    .bus(bus_b), .line_busy(line_busy_b), .line_done(line_done_b),
    .line_aborted(line_aborted_b), .line_cnt(line_cnt_b)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (timeline view of a line) ----------------
  bit          m_busy, m_load, m_we, m_done, m_abt;
  int          m_words, m_off;
  logic [15:0] m_cnt, m_wdata;
  logic [7:0]  m_waddr;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_load = 0; m_we = 0; m_done = 0; m_abt = 0;
      m_words = 0; m_off = 0; m_cnt = '0; m_wdata = '0; m_waddr = '0;
    end else begin
      m_we = 0; m_done = 0; m_abt = 0;
      if (!m_busy) begin
        if (line_req) begin
          m_busy = 1; m_load = cfg_load; m_words = 0; m_waddr = '0; m_off = 0;
        end
      end else if (abort) begin
        m_busy = 0; m_load = 0; m_abt = 1;
      end else if (m_load) begin
        if (m_words == NZ) begin
          m_load = 0; m_off = 0;
        end else if (bus.cfg_valid) begin
          m_we = 1; m_waddr = 8'(m_words); m_wdata = bus.cfg_data; m_words++;
        end
      end else begin
        m_off++;
        if (m_off == TOT) begin
          m_done = 1; m_cnt = m_cnt + 16'd1;
        end else if (m_off > TOT) begin
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial forever begin
    bit   e_line, e_tx, e_st, e_ready, e_busy, e_we, e_done, e_abt;
    int   e_addr, s;
    logic [15:0] e_cnt, e_wdata;
    @(negedge clk);
    if (rst) begin
      e_tx = 0; e_st = 0; e_ready = 0; e_busy = 0; e_we = 0; e_done = 0; e_abt = 0;
      e_addr = 0; e_cnt = '0; e_wdata = '0;
    end else begin
      e_line  = m_busy && !m_load;
      e_tx    = e_line && (m_off < TXL);
      e_st    = e_line && (m_off >= TXL + DL) && (m_off < TOT);
      e_ready = m_busy && m_load && (m_words < NZ);
      e_busy  = m_busy;
      e_we    = m_we;
      e_done  = m_done;
      e_abt   = m_abt;
      e_cnt   = m_cnt;
      e_wdata = m_wdata;
      if (m_busy && m_load) e_addr = int'(m_waddr);
      else if (e_st) begin
        s = (m_off - TXL - DL) >> ZSH;
        e_addr = (s < NZ - 1) ? s : NZ - 1;
      end else e_addr = 0;
    end
    chk("m_tx_en",     32'(bus.tx_en),        32'(e_tx));
    chk("m_start",     32'(bus.start),        32'(e_st));
    chk("m_addr",      32'(bus.dbf_lut_addr), 32'(e_addr));
    chk("m_we",        32'(bus.dbf_lut_we),   32'(e_we));
    chk("m_wdata",     32'(bus.lut_wdata),    32'(e_wdata));
    chk("m_cfg_ready", 32'(bus.cfg_ready),    32'(e_ready));
    chk("m_busy",      32'(line_busy),        32'(e_busy));
    chk("m_done",      32'(line_done),        32'(e_done));
    chk("m_aborted",   32'(line_aborted),     32'(e_abt));
    chk("m_line_cnt",  32'(line_cnt),         32'(e_cnt));
  end

  // ---------------- LUT write monitor (literal order/data rule) ----------------
  int cyc = 0, w_idx = 0, we_total = 0, last_we_cyc = 0, tx_rise_cyc = 0;
  bit prev_tx = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!line_busy) w_idx = 0;
    if (!rst && bus.dbf_lut_we) begin
      chk("we_addr_order", 32'(bus.dbf_lut_addr), 32'(w_idx));
      chk("we_data",       32'(bus.lut_wdata),    32'h1000 + 32'(w_idx));
      w_idx++; we_total++; last_we_cyc = cyc;
    end
    if (bus.tx_en && !prev_tx) tx_rise_cyc = cyc;
    prev_tx = bus.tx_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!line_done && n < limit) begin @(negedge clk); n++; end
    chk(name, 32'(line_done), 1);
  endtask

  task automatic wait_start(input string name, input int limit);
    int n = 0;
    while (!bus.start && n < limit) begin @(negedge clk); n++; end
    chk(name, 32'(bus.start), 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n_tx, n_st, first_tx, first_st, done_i, k, c, base, n;
    rst = 1; line_req = 0; cfg_load = 0; abort = 0; line_req_b = 0;
    bus.cfg_valid = 0; bus.cfg_data = '0; bus_b.cfg_valid = 0; bus_b.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(line_busy), 0);
    chk("rst_cnt",  32'(line_cnt), 0);
    chk("rst_addr", 32'(bus.dbf_lut_addr), 0);
    rst = 0;

    // 1: plain line, with line_req pulses during TX and RX that must be ignored
    @(posedge clk); #1; line_req = 1; cfg_load = 0;
    @(posedge clk); #1; line_req = 0;
    n_tx = 0; n_st = 0; first_tx = -1; first_st = -1; done_i = -1;
    for (int i = 0; i < TOT + 4; i++) begin
      @(negedge clk);
      if (bus.tx_en) begin n_tx++; if (first_tx < 0) first_tx = i; end
      if (bus.start) begin n_st++; if (first_st < 0) first_st = i; end
      if (line_done) done_i = i;
      line_req = (i == 5 || i == 1000);
    end
    line_req = 0;
    chk("t1_tx_count",    32'(n_tx), 16);
    chk("t1_tx_first",    32'(first_tx), 0);
    chk("t1_start_count", 32'(n_st), 4096);
    chk("t1_start_first", 32'(first_st), 80);
    chk("t1_done_at",     32'(done_i), 4176);
    chk("t1_line_cnt",    32'(line_cnt), 1);

    // 2: LUT load, 256 words 0x1000+i, cfg_valid toggling
    @(posedge clk); #1; line_req = 1; cfg_load = 1;
    @(posedge clk); #1; line_req = 0; cfg_load = 0;
    base = we_total; k = 0; c = 0;
    while (k < NZ && c < 4 * NZ) begin
      bus.cfg_valid = (c % 2 == 1);
      bus.cfg_data  = 16'h1000 + 16'(k);
      @(posedge clk);
      if (bus.cfg_valid) k++;
      #1; c++;
    end
    bus.cfg_valid = 0;
    chk("t2_words_sent", 32'(k), NZ);
    wait_done("t2_done_seen", TOT + 50);
    chk("t2_we_pulses",   32'(we_total - base), 256);
    chk("t2_tx_after_we", 32'(tx_rise_cyc - last_we_cyc), 1);
    chk("t2_line_cnt",    32'(line_cnt), 2);
    @(posedge clk); #1;

    // 4a: abort in LOAD after 10 words
    line_req = 1; cfg_load = 1;
    @(posedge clk); #1; line_req = 0; cfg_load = 0;
    base = we_total;
    for (int i = 0; i < 10; i++) begin
      bus.cfg_valid = 1; bus.cfg_data = 16'h1000 + 16'(i);
      @(posedge clk); #1;
    end
    bus.cfg_valid = 0; abort = 1;
    @(posedge clk); #1; abort = 0;
    chk("t4a_aborted",  32'(line_aborted), 1);
    chk("t4a_busy",     32'(line_busy), 0);
    chk("t4a_ready",    32'(bus.cfg_ready), 0);
    chk("t4a_addr",     32'(bus.dbf_lut_addr), 0);
    chk("t4a_we_count", 32'(we_total - base), 10);
    chk("t4a_line_cnt", 32'(line_cnt), 2);
    @(posedge clk); #1;
    chk("t4a_pulse_end", 32'(line_aborted), 0);

    // 4b: abort at RX sample 100
    line_req = 1;
    @(posedge clk); #1; line_req = 0;
    wait_start("t4b_start_seen", 200);
    repeat (100) @(negedge clk);
    chk("t4b_addr_s100", 32'(bus.dbf_lut_addr), 6);
    abort = 1;
    @(posedge clk); #1; abort = 0;
    chk("t4b_aborted",  32'(line_aborted), 1);
    chk("t4b_start",    32'(bus.start), 0);
    chk("t4b_addr",     32'(bus.dbf_lut_addr), 0);
    chk("t4b_line_cnt", 32'(line_cnt), 2);
    @(posedge clk); #1;

    // abort with line_req in IDLE: line starts, held abort kills it next cycle
    line_req = 1; abort = 1;
    @(posedge clk); #1; line_req = 0;
    chk("t4c_tx_started", 32'(bus.tx_en), 1);
    @(posedge clk); #1; abort = 0;
    chk("t4c_aborted",  32'(line_aborted), 1);
    chk("t4c_tx_off",   32'(bus.tx_en), 0);
    chk("t4c_line_cnt", 32'(line_cnt), 2);
    @(posedge clk); #1;

    // 5: reset mid-RX clears everything immediately
    line_req = 1;
    @(posedge clk); #1; line_req = 0;
    wait_start("t5_start_seen", 200);
    repeat (50) @(negedge clk);
    @(posedge clk); #1; rst = 1; #1;
    chk("t5_start", 32'(bus.start), 0);
    chk("t5_busy",  32'(line_busy), 0);
    chk("t5_cnt",   32'(line_cnt), 0);
    chk("t5_addr",  32'(bus.dbf_lut_addr), 0);
    @(posedge clk); #1; rst = 0;

    // 3: long RX window, zone address steps every 16 and saturates at 255
    @(posedge clk); #1; line_req_b = 1;
    @(posedge clk); #1; line_req_b = 0;
    n = 0;
    while (!bus_b.start && n < 200) begin @(negedge clk); n++; end
    chk("b_start_seen", 32'(bus_b.start), 1);
    for (int s = 0; s < RXL_B; s++) begin
      chk("b_start", 32'(bus_b.start), 1);
      chk("b_addr",  32'(bus_b.dbf_lut_addr), 32'(((s >> 4) < 255) ? (s >> 4) : 255));
      if (s == 15)   chk("b_addr_s15",   32'(bus_b.dbf_lut_addr), 0);
      if (s == 16)   chk("b_addr_s16",   32'(bus_b.dbf_lut_addr), 1);
      if (s == 4095) chk("b_addr_s4095", 32'(bus_b.dbf_lut_addr), 255);
      if (s == 8191) chk("b_addr_s8191", 32'(bus_b.dbf_lut_addr), 255);
      @(negedge clk);
    end
    chk("b_done",     32'(line_done_b), 1);
    chk("b_start_lo", 32'(bus_b.start), 0);
    chk("b_line_cnt", 32'(line_cnt_b), 1);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
